hamming_err_logger: RTL

Downstream consumer of the counter's Hamming-nibble syndrome stage. It watches the per-nibble 3-bit syndromes and the error-detected flag during a hold period (enable low). It classifies each nibble's error as a data-bit or a parity-bit error and logs one event record per hold period into a small FIFO. The records are drained over a valid/ready port, and the block keeps saturating statistics and raises an interrupt for software.

---
 rtl/hamming_err_logger.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/hamming_err_logger.sv
// Hamming nibble error logger: classifies per-nibble syndromes during a hold period,
// logs one event per hold into a FWFT FIFO and keeps saturating statistics.
module hamming_err_logger #(
  parameter int WIDTH       = 64,
  parameter int BLOCKS      = WIDTH / 4,
  parameter int PARITY_BITS = BLOCKS * 3,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   error_detected,
  input  logic [PARITY_BITS-1:0] syndrome,
  input  logic [WIDTH-1:0]       counter,
  input  logic                   clear_stats,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [WIDTH-1:0]       ev_counter,
  output logic [BLOCKS-1:0]      ev_data_mask,
  output logic [BLOCKS-1:0]      ev_parity_mask,
  output logic [15:0]            event_count,
  output logic [15:0]            nibble_err_count,
  output logic                   overflow,
  output logic                   irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CAPTURE = 2'd1,
    PUSH    = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  function automatic logic is_data_err(input logic [2:0] syn);
    case (syn)
      3'b011, 3'b101, 3'b110, 3'b111: is_data_err = 1'b1;
      default:                        is_data_err = 1'b0;
    endcase
  endfunction

  function automatic logic is_parity_err(input logic [2:0] syn);
    case (syn)
      3'b001, 3'b010, 3'b100: is_parity_err = 1'b1;
      default:                is_parity_err = 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] popcount(input logic [BLOCKS-1:0] v);
    logic [15:0] cnt;
    cnt = 16'd0;
    for (int i = 0; i < BLOCKS; i++) begin
      cnt = cnt + 16'(v[i]);
    end
    popcount = cnt;
  endfunction

  state_t                 state_r, state_nxt_s;
  logic [PARITY_BITS-1:0] cap_syn_r;
  logic [WIDTH-1:0]       cap_cnt_r;
  logic [BLOCKS-1:0]      data_mask_s, parity_mask_s;
  logic [BLOCKS-1:0]      dmask_r, pmask_r;
  logic [WIDTH-1:0]       mem_cnt_r [DEPTH];
  logic [BLOCKS-1:0]      mem_dm_r  [DEPTH];
  logic [BLOCKS-1:0]      mem_pm_r  [DEPTH];
  logic [AW:0]            wr_ptr_r, rd_ptr_r, occ_s;
  logic                   push_s, pop_s, full_s, empty_s, wr_en_s, drop_s, arm_hit_s;
  logic [15:0]            event_count_r, nibble_err_count_r;
  logic [16:0]            nib_sum_s;
  logic                   overflow_r;

  // Per-nibble classification of the captured syndrome
  always_comb begin
    data_mask_s   = '0;
    parity_mask_s = '0;
    for (int i = 0; i < BLOCKS; i++) begin
      data_mask_s[i]   = is_data_err(cap_syn_r[i*3 +: 3]);
      parity_mask_s[i] = is_parity_err(cap_syn_r[i*3 +: 3]);
    end
  end

  assign arm_hit_s = !enable && error_detected;

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARMED: begin
        if (arm_hit_s) state_nxt_s = CAPTURE;
        else           state_nxt_s = ARMED;
      end
      CAPTURE: begin
        if ((data_mask_s == '0) && (parity_mask_s == '0)) state_nxt_s = LOCKED;
        else                                              state_nxt_s = PUSH;
      end
      PUSH:    state_nxt_s = LOCKED;
      LOCKED: begin
        // Stay locked for the rest of the hold period so only one event is logged
        if (enable || !error_detected) state_nxt_s = ARMED;
        else                           state_nxt_s = LOCKED;
      end
      default: state_nxt_s = ARMED;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ARMED;
    else       state_r <= state_nxt_s;
  end

  // Capture registers: snapshot on arming, masks latched at the end of CAPTURE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_syn_r <= '0;
      cap_cnt_r <= '0;
      dmask_r   <= '0;
      pmask_r   <= '0;
    end else begin
      if (state_r == ARMED && arm_hit_s) begin
        cap_syn_r <= syndrome;
        cap_cnt_r <= counter;
      end
      if (state_r == CAPTURE) begin
        dmask_r <= data_mask_s;
        pmask_r <= parity_mask_s;
      end
    end
  end

  assign push_s   = (state_r == PUSH);
  assign occ_s    = wr_ptr_r - rd_ptr_r;
  assign full_s   = (occ_s == FULL_OCC);
  assign empty_s  = (occ_s == '0);
  assign pop_s    = !empty_s && ev_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_en_s  = push_s && (!full_s || pop_s);
  assign drop_s   = push_s && full_s && !pop_s;

  // Event FIFO storage and pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_cnt_r[i] <= '0;
        mem_dm_r[i]  <= '0;
        mem_pm_r[i]  <= '0;
      end
    end else begin
      if (wr_en_s) begin
        mem_cnt_r[wr_ptr_r[AW-1:0]] <= cap_cnt_r;
        mem_dm_r[wr_ptr_r[AW-1:0]]  <= dmask_r;
        mem_pm_r[wr_ptr_r[AW-1:0]]  <= pmask_r;
        wr_ptr_r                    <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  assign nib_sum_s = {1'b0, nibble_err_count_r} + {1'b0, popcount(dmask_r | pmask_r)};

  // Saturating statistics and sticky overflow; clear_stats has priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_count_r      <= 16'd0;
      nibble_err_count_r <= 16'd0;
      overflow_r         <= 1'b0;
    end else if (clear_stats) begin
      event_count_r      <= 16'd0;
      nibble_err_count_r <= 16'd0;
      overflow_r         <= 1'b0;
    end else begin
      if (push_s) begin
        event_count_r      <= (event_count_r == 16'hFFFF) ? 16'hFFFF : event_count_r + 16'd1;
        nibble_err_count_r <= nib_sum_s[16] ? 16'hFFFF : nib_sum_s[15:0];
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign ev_valid         = !empty_s;
  assign ev_counter       = mem_cnt_r[rd_ptr_r[AW-1:0]];
  assign ev_data_mask     = mem_dm_r[rd_ptr_r[AW-1:0]];
  assign ev_parity_mask   = mem_pm_r[rd_ptr_r[AW-1:0]];
  assign event_count      = event_count_r;
  assign nibble_err_count = nibble_err_count_r;
  assign overflow         = overflow_r;
  assign irq              = !empty_s || overflow_r;

endmodule
